// File: rtl/mat_vec_pkg.sv
// Shared types and width helpers for the matrix-vector MAC sequencer.
// The ACC_SAT_EN build option (saturating accumulators) lives in mac_lane.
package mat_vec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Accumulator / output element width for a given operand width.
   function automatic int acc_w(input int nbits);
      return 2 * nbits;
   endfunction

   // Column counter width; a single-column matrix still gets one bit.
   function automatic int col_w(input int ndata);
      return (ndata > 1) ? $clog2(ndata) : 1;
   endfunction

   localparam int ACC_W_DEF = acc_w(8);
   localparam int COL_W_DEF = col_w(4);

endpackage

// File: rtl/mat_vec_mac_seq_mac_lane.sv
// One row accumulator: clear, enable, unsigned Nbits x Nbits multiply-add.
// With ACC_SAT_EN defined the sum clamps to all-ones on carry-out.
module mac_lane
   import mat_vec_pkg::*;
#(
   parameter int Nbits = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr,
   input  logic                   en,
   input  logic [Nbits-1:0]       a,
   input  logic [Nbits-1:0]       b,
   output logic [2*Nbits-1:0]     acc
);

   localparam int AW = acc_w(Nbits);

   logic [AW-1:0] prod;
   logic [AW-1:0] nxt;

   assign prod = AW'(a) * AW'(b);

`ifdef ACC_SAT_EN
   logic [AW:0] sum;
   assign sum = {1'b0, acc} + {1'b0, prod};
   // A saturated lane stays saturated: max + anything either carries or is max.
   assign nxt = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
   assign nxt = acc + prod;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= nxt;
      end
   end

endmodule

// File: rtl/mat_vec_mac_seq.sv
// Sequencer for C = M*X: captures a job, runs Ndata MAC steps over Mdata lanes,
// then holds the result until consumed. Build option: ACC_SAT_EN (see mac_lane).
module mat_vec_mac_seq
   import mat_vec_pkg::*;
#(
   parameter int Mdata = 4,
   parameter int Ndata = 4,
   parameter int Nbits = 8
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [Mdata*Ndata*Nbits-1:0]       M,
   input  logic [Ndata*Nbits-1:0]             X,
   input  logic                               flush,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [Mdata*2*Nbits-1:0]           out,
   output logic                               busy,
   output logic [col_w(Ndata)-1:0]            col_idx
);

   localparam int AW = acc_w(Nbits);
   localparam int CW = col_w(Ndata);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and flush cancels either transfer.

   state_t                         state_q, state_d;
   logic [CW-1:0]                  col_q, col_d;
   logic [Mdata*Ndata*Nbits-1:0]   m_q;
   logic [Ndata*Nbits-1:0]         x_q;
   logic                           accept, acc_clr, acc_en, last_col;
   logic [Nbits-1:0]               x_sel;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign col_idx   = col_q;
   assign accept    = in_valid && in_ready && !flush;
   assign last_col  = (col_q == CW'(Ndata - 1));

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      if (flush) begin
         state_d = IDLE;
         col_d   = '0;
         acc_clr = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_d = ACCUM;
                  col_d   = '0;
                  acc_clr = 1'b1;
               end
            end
            ACCUM: begin
               acc_en = 1'b1;
               if (last_col) begin
                  state_d = DONE;
                  col_d   = '0;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q <= '0;
         x_q <= '0;
      end else if (accept) begin
         m_q <= M;
         x_q <= X;
      end
   end

   assign x_sel = x_q[int'(col_q)*Nbits +: Nbits];

   for (genvar r = 0; r < Mdata; r++) begin : g_lane
      logic [Ndata*Nbits-1:0] row;
      logic [Nbits-1:0]       a_sel;

      assign row   = m_q[r*Ndata*Nbits +: Ndata*Nbits];
      assign a_sel = row[int'(col_q)*Nbits +: Nbits];

      mac_lane #(.Nbits(Nbits)) u_lane (
         .clk   (clk),
         .reset (reset),
         .clr   (acc_clr),
         .en    (acc_en),
         .a     (a_sel),
         .b     (x_sel),
         .acc   (out[r*AW +: AW])
      );
   end

endmodule

// File: tb/tb_mat_vec_mac_seq.sv
// Self-checking bench for mat_vec_mac_seq at default parameters (4x4, 8-bit).
// Define ACC_SAT_EN for both RTL and bench to exercise the saturating build.
module tb_mat_vec_mac_seq;

   localparam int MD = 4;
   localparam int ND = 4;
   localparam int NB = 8;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [MD*ND*NB-1:0]   M;
   logic [ND*NB-1:0]      X;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [MD*2*NB-1:0]    out;
   logic                  busy;
   logic [1:0]            col_idx;

   mat_vec_mac_seq #(.Mdata(MD), .Ndata(ND), .Nbits(NB)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .M         (M),
      .X         (X),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy),
      .col_idx   (col_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] m;
      logic [31:0]  x;
      logic [63:0]  exp;
   } vec_t;

   vec_t        tbl[6];
   logic [63:0] exp_q[$];
   logic [63:0] cur_exp;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          hs_cyc = 0;
   logic        prev_ov = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: row-by-row dot product with the build's overflow rule.
   function automatic logic [63:0] model(input logic [127:0] m, input logic [31:0] x);
      logic [63:0] res;
      logic [15:0] a;
      logic [15:0] p;
      logic [16:0] s;
      res = '0;
      for (int r = 0; r < MD; r++) begin
         a = '0;
         for (int k = 0; k < ND; k++) begin
            p = 16'(m[(r*ND + k)*NB +: NB]) * 16'(x[k*NB +: NB]);
            s = {1'b0, a} + {1'b0, p};
`ifdef ACC_SAT_EN
            a = s[16] ? 16'hFFFF : s[15:0];
`else
            a = s[15:0];
`endif
         end
         res[r*16 +: 16] = a;
      end
      return res;
   endfunction

   // Scoreboard monitor: push on accept, pop on result handshake, drop on flush.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         if (flush) begin
            if (busy && exp_q.size() > 0) void'(exp_q.pop_front());
         end else begin
            if (in_valid && in_ready) begin
               exp_q.push_back(cur_exp);
               acc_cyc = cyc;
            end
            if (out_valid && out_ready) begin
               hs_cyc = cyc;
               if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
               else check("result", out, exp_q.pop_front());
            end
         end
         // accept is seen one negedge before the accepting edge, hence ND+1
         if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc), 64'(ND + 1));
      end
      prev_ov = out_valid;
   end

   task automatic wait_accept();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      M = {$urandom(), $urandom(), $urandom(), $urandom()};
      X = $urandom();
   endtask

   task automatic run_job(input logic [127:0] m, input logic [31:0] x, input logic [63:0] e, input int hold);
      @(posedge clk); #1;
      M = m; X = x; cur_exp = e; in_valid = 1'b1;
      wait_accept();
      for (int k = 0; k < ND; k++) begin
         @(negedge clk);
         check("col_idx", 64'(col_idx), 64'(k));
         check("busy_accum", 64'(busy), 64'd1);
         check("early_out_valid", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      check("out_valid_rise", 64'(out_valid), 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         in_valid = (i % 2 == 0);
         M = {$urandom(), $urandom(), $urandom(), $urandom()};
         X = $urandom();
         @(negedge clk);
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_out_stable", out, e);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("post_hs_out_valid", 64'(out_valid), 64'd0);
      check("post_hs_in_ready", 64'(in_ready), 64'd1);
      check("post_hs_out_retained", out, e);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_out"}, out, 64'd0);
      check({tag, "_col_idx"}, 64'(col_idx), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ovf;
      logic        ok;
      int          hs_a, acc_b;

`ifdef ACC_SAT_EN
      ovf = {4{16'd65535}};
`else
      ovf = {4{16'd63492}};
`endif
      tbl[0] = '{128'h01030502_04050000_04030201_05060701, 32'h01020101,
                 {16'd14, 16'd14, 16'd13, 16'd25}};
      tbl[1] = '{{128{1'b1}}, 32'hFFFFFFFF, ovf};
      for (int i = 2; i < 6; i++) begin
         tbl[i].m   = {$urandom(), $urandom(), $urandom(), $urandom()};
         tbl[i].x   = $urandom();
         tbl[i].exp = model(tbl[i].m, tbl[i].x);
      end

      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      M = '0; X = '0; cur_exp = '0;
      repeat (3) @(posedge clk);
      #1 check_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b1;

      for (int i = 0; i < 6; i++) run_job(tbl[i].m, tbl[i].x, tbl[i].exp, (i == 0) ? 10 : $urandom_range(0, 3));

      // back-to-back: in_valid held high, out_ready held high
      @(posedge clk); #1;
      M = tbl[0].m; X = tbl[0].x; cur_exp = tbl[0].exp; in_valid = 1'b1; out_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      check("b2b_first_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1;
      hs_a = hs_cyc;
      M = tbl[3].m; X = tbl[3].x; cur_exp = tbl[3].exp;
      @(posedge clk); #1;
      in_valid = 1'b0;
      acc_b = acc_cyc;
      check("b2b_gap", 64'(acc_b - hs_a), 64'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1'b1; break; end
      end
      check("b2b_second_timeout", 64'(ok), 64'd1);
      @(posedge clk); #1 out_ready = 1'b0;

      // flush during ACCUM at col_idx 2
      @(posedge clk); #1;
      M = tbl[4].m; X = tbl[4].x; cur_exp = tbl[4].exp; in_valid = 1'b1;
      wait_accept();
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (col_idx == 2'd1) begin ok = 1'b1; break; end
      end
      check("flush_reach_col1", 64'(ok), 64'd1);
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      check("flush_at_col2", 64'(col_idx), 64'd2);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check_reset_vals("flush");
      ok = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      check("flush_no_out_valid", 64'(ok), 64'd0);
      run_job(tbl[5].m, tbl[5].x, tbl[5].exp, 1);

      // async reset between edges mid-ACCUM
      @(posedge clk); #1;
      M = tbl[2].m; X = tbl[2].x; cur_exp = tbl[2].exp; in_valid = 1'b1;
      wait_accept();
      @(negedge clk);
      @(posedge clk); #3;
      reset = 1'b0;
      exp_q.delete();
      #1 check_reset_vals("async_reset");
      @(posedge clk); #1 reset = 1'b1;
      ok = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) ok = 1'b1;
      end
      check("reset_no_out_valid", 64'(ok), 64'd0);
      run_job(tbl[0].m, tbl[0].x, tbl[0].exp, 2);
      run_job(tbl[1].m, tbl[1].x, tbl[1].exp, 0);

      repeat (3) @(posedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mat_vec_mac_seq.md
Name: mat_vec_mac_seq

Overview:
Sequencer for the multiply-accumulate matrix-vector datapath. It accepts one matrix/vector job through a valid/ready handshake and captures the operands. It then steps a column counter so that Mdata row accumulators perform one MAC per cycle. It presents the result vector through a valid/ready output handshake. It sits between the job source (host or DMA-style feeder) and the downstream consumer of C = M·X.

Parameters:
Mdata, 4, number of matrix rows, equal to the number of output elements and accumulators
Ndata, 4, number of matrix columns, equal to the vector length and the MAC steps per job
Nbits, 8, unsigned operand width; accumulator and output element width is 2*Nbits

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 resets)
in_valid  in  1  job present on M/X
in_ready  out  1  sequencer can accept a job
M  in  Mdata*Ndata*Nbits  row r occupies [r*Ndata*Nbits +: Ndata*Nbits]; element k of a row occupies [k*Nbits +: Nbits]
X  in  Ndata*Nbits  element k occupies [k*Nbits +: Nbits]
flush  in  1  synchronous abort; discards the current job
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  Mdata*2*Nbits  row r result occupies [r*2*Nbits +: 2*Nbits]
busy  out  1  high in ACCUM or DONE
col_idx  out  clog2(Ndata), min 1  current column, for debug

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; out=0; col_idx=0; all accumulators and operand registers cleared.
- FSM states IDLE, ACCUM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: capture M and X into internal registers, clear all accumulators, set col_idx=0, go to ACCUM. After capture, M/X may change freely.
- ACCUM: in_ready=0. Each cycle, acc[r] <= acc[r] + Mreg[r][col_idx]*Xreg[col_idx] for all r in parallel. Each product is unsigned Nbits x Nbits into 2*Nbits. When col_idx==Ndata-1, go to DONE and reset col_idx to 0; otherwise increment col_idx.
- Latency: out_valid rises exactly Ndata clock edges after the accepting edge, so 4 cycles at defaults.
- Accumulation wraps modulo 2^(2*Nbits) unless ACC_SAT_EN is defined.
- DONE: out_valid=1. out holds the accumulator values, stable until the handshake. On out_ready, go to IDLE, and out_valid=0 on the next cycle. No job is accepted in the same cycle as the result handshake; in_ready returns one cycle later.
- out_ready while not in DONE: ignored. in_valid outside IDLE: ignored; the job is not captured and the source must hold it.
- flush (any state): go to IDLE next edge, out_valid=0, col_idx=0, accumulators cleared. flush has priority over both handshakes in the same cycle.
- Reset mid-job: job lost; no out_valid is produced for it.
- out retains the last result after the handshake until the next job clears the accumulators. out is 0 after reset or flush.

Optional Feature:
ACC_SAT_EN
- Defined: each accumulator update clamps to 2^(2*Nbits)-1 on carry-out. Once saturated, it stays saturated for the rest of the job.
- Undefined: plain modulo-2^(2*Nbits) wrap. Timing and handshakes are identical in both cases.

Decomposition:
- Shared package mat_vec_pkg holds:
  - state encodings IDLE/ACCUM/DONE
  - width helper constants: accumulator width 2*Nbits, column-index width clog2(Ndata) with min 1
- One natural sub-module, mac_lane: a single row accumulator with clear, enable, an Nbits x Nbits multiply and the ACC_SAT_EN clamp. It is instantiated Mdata times by a generate loop.
- The FSM, column counter and operand registers live in mat_vec_mac_seq.

Test Plan:
- Basic job at defaults: rows k3..k0 = {5,6,7,1},{4,3,2,1},{4,5,0,0},{1,3,5,2}; X k3..k0 = {1,2,1,1}. Required: out_valid 4 edges after accept; out rows 0..3 = 25,13,14,14; col_idx steps 0,1,2,3.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_valid stays 1, out stable, in_ready=0. Changing M/X and pulsing in_valid has no effect.
- Back-to-back: two jobs with in_valid held high, out_ready=1. Required: second accept exactly 1 cycle after the first result handshake; second result correct.
- Flush during ACCUM at col_idx=2. Required: IDLE next cycle, in_ready=1, out=0, no out_valid; the next job computes correctly.
- Async reset asserted mid-ACCUM, between clock edges. Required: outputs go to reset values immediately; operation is normal after release.
- Overflow: all elements 255, Ndata=4. Required: out row = 63492 without ACC_SAT_EN, 65535 with ACC_SAT_EN.
